pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Program-counter and instruction-fetch sequencer for the single-cycle RISC-V core. It holds the architectural PC and issues fetch requests to instruction memory over a valid/ready handshake. It presents each fetched instruction for one execute window, then consumes the branch-taken decision from the branch AND gate to pick the next PC: sequential or branch target. It sits between instruction memory and the decode/execute datapath and closes the loop that the branch gate opens.

## Interface
Parameters:
- XLEN, 32, PC/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TRAP_VEC, 32'h0000_0100, redirect address on misaligned branch target (only with macro)

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- take_branch  input  1  branch-taken decision (branch AND zero), sampled only in EXEC
- imm  input  XLEN  sign-extended branch offset, sampled with take_branch
- stall  input  1  holds EXEC; no PC update while high
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  XLEN  fetch address; equals pc
- imem_rsp_valid  input  1  instruction data valid this cycle
- instr_valid  output  1  fetched instruction is being executed this cycle
- pc  output  XLEN  current PC
- pc_plus4  output  XLEN  pc + 4, combinational
- trap  output  1  one-cycle pulse on misaligned-target redirect
- bad_addr  output  XLEN  captured faulting target

## Operation
- FSM states: IDLE, REQ, WAIT, EXEC.
- IDLE: entered on reset. Moves unconditionally to REQ on the next clock.
- REQ: imem_req_valid=1. imem_addr is held stable. Moves to WAIT on a cycle with imem_req_ready=1. imem_rsp_valid in REQ is ignored.
- WAIT: moves to EXEC on the cycle imem_rsp_valid=1. Any number of wait cycles is allowed.
- EXEC: instr_valid=1.
  - If stall=1: stay in EXEC; pc unchanged; take_branch ignored.
  - If stall=0: update pc, then go to REQ.
  - Next pc is pc + imm when take_branch=1, else pc + 4.
- Arithmetic: all adds are modulo 2^XLEN; overflow wraps silently (0xFFFF_FFFC + 4 = 0x0000_0000). imm is treated as two's complement.
- One outstanding request at most. No new request is issued before EXEC completes.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req_valid=0, instr_valid=0, trap=0, bad_addr=0. pc_plus4 = RESET_PC + 4.
- Minimum instruction period with ready and response immediate: 4 cycles from IDLE for the first instruction (IDLE, REQ, WAIT, EXEC). After that, 3 cycles per instruction (REQ, WAIT, EXEC).
- The pc register updates on the clock edge that leaves EXEC. The new value is visible in the following REQ cycle.
- instr_valid and imem_req_valid are never high in the same cycle.
- rst_n low at any point: immediately returns to reset values and abandons any outstanding request. Stale imem_rsp_valid after reset is ignored until the next WAIT.
- take_branch and stall asserted together in EXEC: stall wins; the branch is evaluated on the first non-stalled EXEC cycle.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - In EXEC with stall=0 and take_branch=1, if target[1:0]≠2'b00: pc ← TRAP_VEC, bad_addr ← target, and trap=1 for exactly the cycle after EXEC (the REQ cycle).
  - pc + 4 is never checked.
- PC_MISALIGN_TRAP_EN not defined:
  - The target is loaded unmodified, including low bits.
  - trap is tied 0 and bad_addr is tied 0.

## Test plan
- Reset, ready=1, rsp one cycle after accept, take_branch=0 for 3 instructions -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses 3 cycles apart.
- EXEC at pc=0x20 with take_branch=1, imm=0xFFFF_FFF0 -> next imem_addr=0x10. With imm=0x40 -> next imem_addr=0x60.
- imem_req_ready low for 5 cycles in REQ -> imem_addr stays constant and req_valid stays high; the transition to WAIT occurs on the first ready cycle.
- stall=1 for 3 EXEC cycles with take_branch=1, imm=8 at pc=0x4 -> pc holds at 0x4; after stall drops, next fetch is at 0xC.
- With macro: pc=0x30, take_branch=1, imm=6 -> trap pulse, bad_addr=0x36, next fetch at 0x100. Without macro: next fetch at 0x36 and trap stays 0.
- rst_n asserted in WAIT at pc=0x40, followed by a late imem_rsp_valid -> state returns to IDLE, instr_valid stays 0, and the next fetch is at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch sequencer: IDLE -> REQ -> WAIT -> EXEC loop with branch redirect.
// Optional misaligned-branch-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            take_branch,
  input  logic [XLEN-1:0] imm,
  input  logic            stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap,
  output logic [XLEN-1:0] bad_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    EXEC = 2'b11
  } state_t;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  // Without the trap the target is loaded as-is and trap/bad_addr stay at their reset value of 0.
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_nxt_s;
  logic [XLEN-1:0] seq_s;
  logic [XLEN-1:0] target_s;
  logic            trap_r;
  logic            trap_nxt_s;
  logic [XLEN-1:0] bad_addr_r;
  logic [XLEN-1:0] bad_nxt_s;
  logic            req_valid_r;
  logic            instr_valid_r;

  assign seq_s    = pc_r + PC_STEP;
  assign target_s = pc_r + imm;

  // Next-state and next-PC selection; branch inputs only matter on a non-stalled EXEC cycle.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    trap_nxt_s  = 1'b0;
    bad_nxt_s   = bad_addr_r;
    case (state_r)
      IDLE: state_nxt_s = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      EXEC: begin
        if (stall) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = REQ;
          if (take_branch) begin
            if (TRAP_EN && misaligned(target_s[1:0])) begin
              pc_nxt_s   = TRAP_VEC;
              trap_nxt_s = 1'b1;
              bad_nxt_s  = target_s;
            end else begin
              pc_nxt_s = target_s;
            end
          end else begin
            pc_nxt_s = seq_s;
          end
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, PC and registered handshake/trap outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      trap_r        <= 1'b0;
      bad_addr_r    <= '0;
      req_valid_r   <= 1'b0;
      instr_valid_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      trap_r        <= trap_nxt_s;
      bad_addr_r    <= bad_nxt_s;
      req_valid_r   <= (state_nxt_s == REQ);
      instr_valid_r <= (state_nxt_s == EXEC);
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = pc_r;
  assign instr_valid    = instr_valid_r;
  assign pc             = pc_r;
  assign pc_plus4       = seq_s;
  assign trap           = trap_r;
  assign bad_addr       = bad_addr_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: driver pushes expected fetches, monitor checks them at each new request.
module tb_pc_fetch_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic        trap;
    logic [31:0] bad;
  } exp_t;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_NXT  = 32'h0000_0100;
  localparam logic        MIS_TRAP = 1'b1;
  localparam logic [31:0] MIS_BAD  = 32'h0000_0036;
  localparam logic [31:0] BACK_IMM = 32'hFFFF_FF40;
`else
  localparam logic [31:0] MIS_NXT  = 32'h0000_0036;
  localparam logic        MIS_TRAP = 1'b0;
  localparam logic [31:0] MIS_BAD  = 32'h0000_0000;
  localparam logic [31:0] BACK_IMM = 32'h0000_000A;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        take_branch;
  logic [31:0] imm;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [31:0] bad_addr;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_exec = 0;
  exp_t exp_q[$];

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .take_branch(take_branch), .imm(imm), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .trap(trap), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: compare each newly presented fetch against the scoreboard, and check REQ hold behaviour.
  initial begin
    logic        prev_req;
    logic [31:0] prev_addr;
    exp_t        e;
    prev_req  = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req_valid && !prev_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            chk("fetch_addr", imem_addr, e.addr);
            chk("fetch_trap", {31'b0, trap}, {31'b0, e.trap});
            chk("fetch_bad_addr", bad_addr, e.bad);
          end
        end else if (imem_req_valid && prev_req) begin
          chk("req_addr_hold", imem_addr, prev_addr);
          chk("trap_one_cycle", {31'b0, trap}, 32'd0);
        end
        if (imem_req_valid && instr_valid) chk("req_exec_overlap", 32'd1, 32'd0);
        prev_req  = imem_req_valid;
        prev_addr = imem_addr;
      end else begin
        prev_req = 1'b0;
      end
    end
  end

  // One instruction: fetch handshake, EXEC with optional stall, then branch decision.
  task automatic do_instr(input logic [31:0] exp_pc, input int rdy_delay, input int stall_n,
                          input logic br, input logic [31:0] im, input logic [31:0] nxt,
                          input logic nxt_trap, input logic [31:0] nxt_bad, input logic chk_gap);
    int n;
    exp_q.push_back('{addr: nxt, trap: nxt_trap, bad: nxt_bad});
    n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", {31'b0, imem_req_valid}, 32'd1);
    for (int i = 0; i < rdy_delay; i++) begin
      imem_req_ready = 1'b0;
      @(negedge clk);
      chk("req_held_no_ready", {31'b0, imem_req_valid}, 32'd1);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait_after_ready", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("exec_valid", {31'b0, instr_valid}, 32'd1);
    chk("exec_pc", pc, exp_pc);
    chk("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
    if (chk_gap) chk("exec_period", cyc - last_exec, 32'd3);
    last_exec = cyc;
    take_branch = br;
    imm = im;
    stall = (stall_n > 0);
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk);
      chk("stall_exec_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc_hold", pc, exp_pc);
    end
    stall = 1'b0;
    @(negedge clk);
    take_branch = 1'b0;
    imm = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Directed stimulus with hand-computed next fetch addresses.
  initial begin
    rst_n = 1'b0;
    take_branch = 1'b0;
    imm = 32'h0;
    stall = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);
    chk("rst_bad_addr", bad_addr, 32'h0);

    exp_q.push_back('{addr: 32'h0, trap: 1'b0, bad: 32'h0});
    rst_n = 1'b1;
    last_exec = cyc;
    do_instr(32'h0000_0000, 0, 0, 1'b0, 32'h0,         32'h0000_0004, 1'b0, 32'h0, 1'b1);
    do_instr(32'h0000_0004, 0, 0, 1'b0, 32'h0,         32'h0000_0008, 1'b0, 32'h0, 1'b1);
    do_instr(32'h0000_0008, 0, 0, 1'b0, 32'h0,         32'h0000_000C, 1'b0, 32'h0, 1'b1);
    do_instr(32'h0000_000C, 0, 0, 1'b1, 32'h14,        32'h0000_0020, 1'b0, 32'h0, 1'b1);
    do_instr(32'h0000_0020, 0, 0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0, 32'h0, 1'b1);
    do_instr(32'h0000_0010, 0, 0, 1'b1, 32'h10,        32'h0000_0020, 1'b0, 32'h0, 1'b1);
    do_instr(32'h0000_0020, 5, 0, 1'b1, 32'h40,        32'h0000_0060, 1'b0, 32'h0, 1'b0);
    do_instr(32'h0000_0060, 0, 0, 1'b1, 32'hFFFF_FFA4, 32'h0000_0004, 1'b0, 32'h0, 1'b0);
    do_instr(32'h0000_0004, 0, 3, 1'b1, 32'h8,         32'h0000_000C, 1'b0, 32'h0, 1'b1);
    do_instr(32'h0000_000C, 0, 0, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    do_instr(32'hFFFF_FFFC, 0, 0, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 32'h0, 1'b1);
    do_instr(32'h0000_0000, 0, 0, 1'b1, 32'h30,        32'h0000_0030, 1'b0, 32'h0, 1'b1);
    do_instr(32'h0000_0030, 0, 0, 1'b1, 32'h6,         MIS_NXT,       MIS_TRAP, MIS_BAD, 1'b1);
    do_instr(MIS_NXT,       0, 0, 1'b1, BACK_IMM,      32'h0000_0040, 1'b0, MIS_BAD, 1'b1);

    // Reset during WAIT at pc=0x40 with a late response arriving across reset.
    chk("pre_rst_pc", pc, 32'h0000_0040);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    exp_q.push_back('{addr: 32'h0, trap: 1'b0, bad: 32'h0});
    rst_n = 1'b0;
    imem_rsp_valid = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("async_rst_bad_addr", bad_addr, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_stale_rsp", {31'b0, instr_valid}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_exec", {31'b0, instr_valid}, 32'd0);
      chk("post_rst_req", {31'b0, imem_req_valid}, 32'd1);
    end
    imem_rsp_valid = 1'b0;
    do_instr(32'h0000_0000, 0, 0, 1'b0, 32'h0,         32'h0000_0004, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
